// File: rtl/lcd_timing_pkg.sv
// lcd_timing_pkg: shared raster phase type and region-boundary helpers
package lcd_timing_pkg;
  typedef enum logic [1:0] {PH_SYNC, PH_BACK, PH_ACTIVE, PH_FRONT} phase_t;
  function automatic logic [15:0] act_start(int sync, int bp);
    return 16'(sync + bp);
  endfunction
  function automatic logic [15:0] act_end(int sync, int bp, int act);
    return 16'(sync + bp + act);
  endfunction
  function automatic logic [15:0] axis_total(int sync, int bp, int act, int fp);
    return 16'(sync + bp + act + fp);
  endfunction
endpackage

// File: rtl/lcd_axis_counter.sv
// lcd_axis_counter: one raster axis; position counter plus SYNC/BACK/ACTIVE/FRONT phase
module lcd_axis_counter
  import lcd_timing_pkg::*;
#(
  parameter int SYNC = 1,
  parameter int BP   = 1,
  parameter int ACT  = 1,
  parameter int FP   = 1
) (
  input  logic        pixel_clk,
  input  logic        rst,
  input  logic        step,
  output logic [15:0] count,
  output phase_t      phase,
  output logic        wrap
);
  localparam logic [15:0] SYNC_END  = 16'(SYNC);
  localparam logic [15:0] ACT_START = act_start(SYNC, BP);
  localparam logic [15:0] ACT_END   = act_end(SYNC, BP, ACT);
  localparam logic [15:0] LAST      = axis_total(SYNC, BP, ACT, FP) - 16'd1;
  logic [15:0] nxt;
  phase_t      phase_nxt;
  assign wrap = step && count == LAST;
  assign nxt  = wrap ? 16'd0 : count + 16'd1;
  // phase moves when the next position lands on a region boundary
  always_comb
    phase_nxt = (phase == PH_SYNC   && nxt == SYNC_END)  ? PH_BACK   :
                (phase == PH_BACK   && nxt == ACT_START) ? PH_ACTIVE :
                (phase == PH_ACTIVE && nxt == ACT_END)   ? PH_FRONT  :
                (phase == PH_FRONT  && wrap)             ? PH_SYNC   : phase;
  always_ff @(posedge pixel_clk or negedge rst)
    if (!rst) begin
      count <= '0;
      phase <= PH_SYNC;
    end else if (step) begin
      count <= nxt;
      phase <= phase_nxt;
    end
endmodule

// File: rtl/lcd_timing_gen.sv
// lcd_timing_gen: LCD raster timing (sync, data enable, line/frame strobes)
module lcd_timing_gen
  import lcd_timing_pkg::*;
#(
  parameter int   H_ACTIVE = 800,
  parameter int   H_FP     = 40,
  parameter int   H_SYNC   = 48,
  parameter int   H_BP     = 40,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 13,
  parameter int   V_SYNC   = 3,
  parameter int   V_BP     = 29,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0
) (
  input  logic        pixel_clk,
  input  logic        rst,
  input  logic        en,
  output logic [15:0] x,
  output logic [15:0] y,
  output logic        LCD_HYNC,
  output logic        LCD_SYNC,
  output logic        LCD_DEN,
  output logic        line_start,
  output logic        frame_start,
  output logic [7:0]  frame_count
);
  phase_t h_phase, v_phase;
  logic   h_wrap, v_wrap;
  lcd_axis_counter #(.SYNC(H_SYNC), .BP(H_BP), .ACT(H_ACTIVE), .FP(H_FP)) u_h (
    .pixel_clk, .rst, .step(en), .count(x), .phase(h_phase), .wrap(h_wrap)
  );
  lcd_axis_counter #(.SYNC(V_SYNC), .BP(V_BP), .ACT(V_ACTIVE), .FP(V_FP)) u_v (
    .pixel_clk, .rst, .step(h_wrap), .count(y), .phase(v_phase), .wrap(v_wrap)
  );
  // sync/DEN decode registered phase state, so they line up with x/y
  assign LCD_HYNC = (h_phase == PH_SYNC) ? HS_POL : ~HS_POL;
  assign LCD_SYNC = (v_phase == PH_SYNC) ? VS_POL : ~VS_POL;
  assign LCD_DEN  = en && h_phase == PH_ACTIVE && v_phase == PH_ACTIVE;
  always_ff @(posedge pixel_clk or negedge rst)
    if (!rst) begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_count <= '0;
    end else begin
      line_start  <= h_wrap;
      frame_start <= v_wrap;
      frame_count <= frame_count + {7'd0, v_wrap};
    end
endmodule

// File: tb/tb_lcd_timing_gen.sv
// tb_lcd_timing_gen: arithmetic raster model, vector table and corner sequences
module tb_lcd_timing_gen;
  localparam int HA = 8, HF = 2, HS = 1, HB = 3;
  localparam int VA = 4, VF = 1, VS = 1, VB = 2;
  localparam int HT = HS + HB + HA + HF;
  localparam int VT = VS + VB + VA + VF;
  localparam int FT = HT * VT;
  logic pixel_clk = 0, rst = 1, en = 0;
  logic [15:0] x, y;
  logic hs, vs, den, ls, fs;
  logic [7:0] fc;
  int ncmp = 0, nerr = 0, t = 0;
  bit adv = 0;
  typedef struct {bit en; int ex; int ey; bit eden;} vec_t;
  vec_t tbl[7];
  lcd_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut (
    .pixel_clk(pixel_clk), .rst(rst), .en(en), .x(x), .y(y),
    .LCD_HYNC(hs), .LCD_SYNC(vs), .LCD_DEN(den),
    .line_start(ls), .frame_start(fs), .frame_count(fc)
  );
  always #5 pixel_clk = ~pixel_clk;
  task automatic cmp(string name, int act, int exp);
    ncmp++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d (t=%0d, time %0t)", name, act, exp, t, $time);
    end
  endtask
  // expected outputs from raster position t = count of advancing edges since reset
  task automatic check_model();
    int ex, ey;
    ex = t % HT;
    ey = (t / HT) % VT;
    cmp("x", int'(x), ex);
    cmp("y", int'(y), ey);
    cmp("hsync", int'(hs), (ex < HS) ? 0 : 1);
    cmp("vsync", int'(vs), (ey < VS) ? 0 : 1);
    cmp("den", int'(den), int'(en && ex >= HS + HB && ex < HS + HB + HA && ey >= VS + VB && ey < VS + VB + VA));
    cmp("line_start", int'(ls), int'(adv && ex == 0));
    cmp("frame_start", int'(fs), int'(adv && ex == 0 && ey == 0));
    cmp("frame_count", int'(fc), (t / FT) % 256);
  endtask
  task automatic tick();
    @(posedge pixel_clk);
    adv = rst && en;
    if (adv) t++;
    @(negedge pixel_clk);
    check_model();
  endtask
  task automatic run_to(int target);
    en = 1;
    for (int i = 0; i < FT && t % FT != target; i++) tick();
  endtask
  initial begin
    int den_cnt, last_fs, nfr, first_fs;
    for (int i = 0; i < 5; i++) tbl[i] = '{1'b0, 6, 4, 1'b0};
    tbl[5] = '{1'b1, 7, 4, 1'b1};
    tbl[6] = '{1'b1, 8, 4, 1'b1};
    #2 rst = 0;
    #1 check_model();
    repeat (2) tick();
    rst = 1;
    en = 1;
    den_cnt = 0; last_fs = 0; nfr = 0;
    for (int i = 1; i <= 3 * FT; i++) begin
      tick();
      if (den) den_cnt++;
      if (fs) begin
        nfr++;
        cmp("den_per_frame", den_cnt, HA * VA);
        cmp("fs_interval", i - last_fs, FT);
        cmp("fc_step", int'(fc), nfr);
        last_fs = i;
        den_cnt = 0;
      end
    end
    cmp("frames_seen", nfr, 3);
    run_to(4 * HT + 6);
    for (int i = 0; i < 7; i++) begin
      en = tbl[i].en;
      #1 check_model();
      tick();
      cmp("tbl_x", int'(x), tbl[i].ex);
      cmp("tbl_y", int'(y), tbl[i].ey);
      cmp("tbl_den", int'(den), int'(tbl[i].eden));
    end
    run_to(FT - 1);
    tick();
    cmp("wrap_x", int'(x), 0);
    cmp("wrap_y", int'(y), 0);
    cmp("wrap_ls", int'(ls), 1);
    cmp("wrap_fs", int'(fs), 1);
    en = 0;
    repeat (2) begin
      tick();
      cmp("frozen_x", int'(x), 0);
      cmp("frozen_y", int'(y), 0);
      cmp("frozen_ls", int'(ls), 0);
      cmp("frozen_fs", int'(fs), 0);
    end
    repeat (300) begin
      en = $urandom_range(0, 3) != 0;
      tick();
    end
    run_to(5 * HT + 9);
    #2 rst = 0;
    #1;
    cmp("rst_x", int'(x), 0);
    cmp("rst_y", int'(y), 0);
    cmp("rst_hs", int'(hs), 0);
    cmp("rst_vs", int'(vs), 0);
    cmp("rst_den", int'(den), 0);
    cmp("rst_ls", int'(ls), 0);
    cmp("rst_fs", int'(fs), 0);
    cmp("rst_fc", int'(fc), 0);
    t = 0;
    adv = 0;
    @(negedge pixel_clk);
    check_model();
    rst = 1;
    first_fs = 0;
    for (int i = 1; i <= FT; i++) begin
      tick();
      if (fs && first_fs == 0) first_fs = i;
    end
    cmp("first_fs_after_rst", first_fs, FT);
    cmp("fc_after_rst", int'(fc), 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
